// File: rtl/melody_player_if.sv
// Control, melody-ROM and sample-output signals of the melody player.
// The slave side is the player; the master side drives controls and returns ROM data.
interface melody_player_if #(
    parameter int SAMPLE_W = 8,
    parameter int PHASE_W  = 24,
    parameter int ADDR_W   = 6
);
    logic                start;
    logic                stop;
    logic                loop_en;
    logic [1:0]          wave_sel;
    logic [ADDR_W-1:0]   mel_addr;
    logic [PHASE_W-1:0]  mel_data;
    logic [SAMPLE_W-1:0] sample;
    logic                busy;
    logic                done;

    modport master (
        output start, stop, loop_en, wave_sel, mel_data,
        input  mel_addr, sample, busy, done
    );

    modport slave (
        input  start, stop, loop_en, wave_sel, mel_data,
        output mel_addr, sample, busy, done
    );
endinterface

// File: rtl/melody_player.sv
// Melody sequencer and DDS tone generator: walks a tuning-word ROM, plays each
// note for a fixed tick count through a phase accumulator and waveform shaper.
//
// state   | meaning
// S_IDLE  | waiting for start, sample parked at mid-scale
// S_FETCH | ROM address stable, data arrives next cycle
// S_LOAD  | latch tuning word and waveform, reset accumulator and note timer
// S_PLAY  | accumulate phase, register one sample per cycle
// S_DONE  | one-cycle completion pulse, then back to idle
module melody_player #(
    parameter int SAMPLE_W       = 8,
    parameter int PHASE_W        = 24,
    parameter int NOTE_CNT       = 42,
    parameter int ADDR_W         = 6,
    parameter int TICKS_PER_NOTE = 10000000
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    melody_player_if.slave  bus
);

    localparam int TICK_W = (TICKS_PER_NOTE > 1) ? $clog2(TICKS_PER_NOTE) : 1;

    localparam logic [SAMPLE_W-1:0] MID        = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [ADDR_W-1:0]   LAST_ADDR  = ADDR_W'(NOTE_CNT - 1);
    localparam logic [TICK_W-1:0]   TICK_LOAD  = TICK_W'(TICKS_PER_NOTE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [PHASE_W-1:0]  r_incr;
    logic [1:0]          r_wmode;
    logic [PHASE_W-1:0]  r_acc;
    logic [TICK_W-1:0]   r_tick;
    logic [SAMPLE_W-1:0] r_sample;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [PHASE_W-1:0]  w_incr_nxt;
    logic [1:0]          w_wmode_nxt;
    logic [PHASE_W-1:0]  w_acc_nxt;
    logic [TICK_W-1:0]   w_tick_nxt;
    logic [SAMPLE_W-1:0] w_sample_nxt;

    logic [SAMPLE_W-1:0] w_phase;
    logic [SAMPLE_W-1:0] w_tri;
    logic [SAMPLE_W-1:0] w_wave;

    // Waveform shaper works on the top SAMPLE_W bits of the accumulator.
    always_comb begin
        w_phase = r_acc[PHASE_W-1 -: SAMPLE_W];
        w_tri   = {w_phase[SAMPLE_W-2:0], 1'b0};
        w_wave  = {SAMPLE_W{w_phase[SAMPLE_W-1]}};
        if (r_incr == '0) begin
            w_wave = MID;
        end else begin
            case (r_wmode)
                2'd1:    w_wave = w_phase;
                2'd2:    w_wave = w_phase[SAMPLE_W-1] ? ~w_tri : w_tri;
                default: w_wave = {SAMPLE_W{w_phase[SAMPLE_W-1]}};
            endcase
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_incr_nxt   = r_incr;
        w_wmode_nxt  = r_wmode;
        w_acc_nxt    = r_acc;
        w_tick_nxt   = r_tick;
        w_sample_nxt = r_sample;

        case (r_state)
            S_IDLE: begin
                w_sample_nxt = MID;
                if (bus.start && !bus.stop) begin
                    w_addr_nxt  = '0;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_incr_nxt  = bus.mel_data;
                w_wmode_nxt = bus.wave_sel;
                w_acc_nxt   = '0;
                w_tick_nxt  = TICK_LOAD;
                w_state_nxt = S_PLAY;
            end
            S_PLAY: begin
                w_acc_nxt    = r_acc + r_incr;
                w_sample_nxt = w_wave;
                if (r_tick == '0) begin
                    if (r_addr != LAST_ADDR) begin
                        w_addr_nxt  = r_addr + ADDR_W'(1);
                        w_state_nxt = S_FETCH;
                    end else if (bus.loop_en) begin
                        w_addr_nxt  = '0;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_tick_nxt = r_tick - TICK_W'(1);
                end
            end
            S_DONE: begin
                w_sample_nxt = MID;
                w_addr_nxt   = '0;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort wins over every transition above, including a note end.
        if (bus.stop && (r_state != S_IDLE)) begin
            w_state_nxt  = S_IDLE;
            w_sample_nxt = MID;
            w_addr_nxt   = '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_incr   <= '0;
            r_wmode  <= 2'd0;
            r_acc    <= '0;
            r_tick   <= '0;
            r_sample <= MID;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_incr   <= w_incr_nxt;
            r_wmode  <= w_wmode_nxt;
            r_acc    <= w_acc_nxt;
            r_tick   <= w_tick_nxt;
            r_sample <= w_sample_nxt;
        end
    end

    assign bus.mel_addr = r_addr;
    assign bus.sample   = r_sample;
    assign bus.busy     = (r_state == S_FETCH) || (r_state == S_LOAD) || (r_state == S_PLAY);
    assign bus.done     = (r_state == S_DONE);

endmodule

// File: tb/tb_melody_player.sv
// Directed bench for melody_player with a 3-entry ROM, 4-bit samples, 8-bit phase
// and 8-tick notes; expected samples are hand-derived from the waveform formulas.
module tb_melody_player;

    localparam int SAMPLE_W = 4;
    localparam int PHASE_W  = 8;
    localparam int NOTE_CNT = 3;
    localparam int ADDR_W   = 2;
    localparam int TICKS    = 8;

    logic CLOCK_50;
    logic reset;

    melody_player_if #(.SAMPLE_W(SAMPLE_W), .PHASE_W(PHASE_W), .ADDR_W(ADDR_W)) bus ();

    melody_player #(
        .SAMPLE_W(SAMPLE_W), .PHASE_W(PHASE_W), .NOTE_CNT(NOTE_CNT),
        .ADDR_W(ADDR_W), .TICKS_PER_NOTE(TICKS)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .bus(bus.slave)
    );

    logic [PHASE_W-1:0] rom [4];

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    int saw2_exp [8] = '{0, 4, 8, 12, 0, 4, 8, 12};
    int tri_exp  [8] = '{0, 4, 8, 12, 15, 11, 7, 3};
    int sq_exp   [8] = '{0, 0, 0, 0, 15, 15, 15, 15};

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge CLOCK_50) bus.mel_data <= rom[bus.mel_addr];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
        if (bus.done) done_cnt++;
    endtask

    initial begin
        rom[0] = 8'd16; rom[1] = 8'd0; rom[2] = 8'd64; rom[3] = 8'd0;
        reset        = 1'b1;
        bus.start    = 1'b1;
        bus.stop     = 1'b0;
        bus.loop_en  = 1'b0;
        bus.wave_sel = 2'd1;

        // Reset dominates a held start.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_sample", bus.sample, 8);
            check("rst_busy", bus.busy, 0);
            check("rst_done", bus.done, 0);
            check("rst_addr", bus.mel_addr, 0);
        end
        reset = 1'b0;
        bus.start = 1'b0;
        step();
        check("idle_busy", bus.busy, 0);

        // Sawtooth run through the whole melody.
        done_cnt = 0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("saw_busy", bus.busy, 1);
        check("saw_addr0", bus.mel_addr, 0);
        step(); step();
        for (int i = 0; i < 8; i++) begin
            step();
            check("saw_note0", bus.sample, i);
        end
        check("saw_addr1", bus.mel_addr, 1);
        step(); step();
        for (int i = 0; i < 8; i++) begin
            step();
            check("rest_note1", bus.sample, 8);
        end
        check("saw_addr2", bus.mel_addr, 2);
        step(); step();
        for (int i = 0; i < 8; i++) begin
            step();
            check("saw_note2", bus.sample, saw2_exp[i]);
        end
        check("saw_done", bus.done, 1);
        check("saw_done_busy", bus.busy, 0);
        step();
        check("saw_done_clr", bus.done, 0);
        check("saw_end_sample", bus.sample, 8);
        check("saw_end_addr", bus.mel_addr, 0);
        check("saw_done_cnt", done_cnt, 1);

        // Loop mode, released during the second pass.
        done_cnt = 0;
        bus.loop_en = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (30) step();
        check("loop_busy", bus.busy, 1);
        check("loop_wrap_addr", bus.mel_addr, 0);
        check("loop_no_done", done_cnt, 0);
        repeat (15) step();
        check("loop_pass2_addr", bus.mel_addr, 1);
        bus.loop_en = 1'b0;
        repeat (15) step();
        check("loop_done", bus.done, 1);
        check("loop_done_cnt", done_cnt, 1);
        step();
        check("loop_end_busy", bus.busy, 0);

        // Stop in the 4th PLAY cycle of note 1, then mid-note 0 of a replay.
        done_cnt = 0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (15) step();
        check("stop_pre_addr", bus.mel_addr, 1);
        check("stop_pre_busy", bus.busy, 1);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check("stop_busy", bus.busy, 0);
        check("stop_sample", bus.sample, 8);
        check("stop_addr", bus.mel_addr, 0);
        step();
        check("stop_stay_idle", bus.busy, 0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("replay_busy", bus.busy, 1);
        check("replay_addr", bus.mel_addr, 0);
        repeat (6) step();
        check("replay_sample", bus.sample, 3);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check("stop2_sample", bus.sample, 8);
        check("stop2_busy", bus.busy, 0);
        check("stop_no_done", done_cnt, 0);

        // Reset in the middle of a note.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (6) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_sample", bus.sample, 8);
        check("midrst_busy", bus.busy, 0);
        check("midrst_addr", bus.mel_addr, 0);

        // Triangle at incr 32.
        rom[0] = 8'd32;
        bus.wave_sel = 2'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); step();
        for (int i = 0; i < 8; i++) begin
            step();
            check("tri_note0", bus.sample, tri_exp[i]);
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;

        // Square; wave_sel and start change mid-note and must not disturb it.
        done_cnt = 0;
        bus.wave_sel = 2'd0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); step();
        for (int i = 0; i < 8; i++) begin
            step();
            check("sq_note0", bus.sample, sq_exp[i]);
            if (i == 1) begin
                bus.wave_sel = 2'd1;
                bus.start = 1'b1;
            end
        end
        check("busy_start_addr1", bus.mel_addr, 1);
        step(); step();
        repeat (8) step();
        check("busy_start_addr2", bus.mel_addr, 2);
        step(); step();
        for (int i = 0; i < 8; i++) begin
            step();
            check("newwave_note2", bus.sample, saw2_exp[i]);
        end
        check("sq_run_done", bus.done, 1);
        check("sq_run_done_cnt", done_cnt, 1);
        bus.start = 1'b0;
        step();
        check("sq_run_end_busy", bus.busy, 0);

        // start and stop together while idle.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step(); step();
        check("startstop_busy", bus.busy, 0);
        check("startstop_addr", bus.mel_addr, 0);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        step();
        check("startstop_idle", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
